// File: rtl/operand_select_pipe.sv
// N-way operand select stage with registered output, valid/ready flow control,
// illegal-select detection and a saturating error counter. OPSEL_SKID_EN adds a skid entry.
module operand_select_pipe #(
  parameter int WIDTH       = 32,
  parameter int NUM_IN      = 3,
  parameter int DEFAULT_IDX = 0,
  localparam int SEL_W      = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic [15:0]             err_count
);

  localparam int SEL_SPAN = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

`ifdef OPSEL_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;
`else
  typedef enum logic [0:0] {ST_EMPTY, ST_ONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]  in_arr [SEL_SPAN];
  logic [WIDTH-1:0]  cap_data;
  logic              cap_err;
  logic              accept;
  logic              transfer;

  // Unused select codes alias the default input so the mux needs no range guard.
  generate
    for (genvar gi = 0; gi < SEL_SPAN; gi++) begin : g_in
      if (gi < NUM_IN) begin : g_real
        assign in_arr[gi] = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_dflt
        assign in_arr[gi] = in_data[DEFAULT_IDX*WIDTH +: WIDTH];
      end
    end
  endgenerate

  assign cap_data  = in_arr[sel];
  assign cap_err   = ({1'b0, sel} >= NUM_IN_L);
  assign out_valid = (state_q != ST_EMPTY);
  assign transfer  = out_valid && out_ready;
  assign accept    = in_valid && in_ready && !flush;

`ifdef OPSEL_SKID_EN
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q;

  assign in_ready = in_ready_q;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d    = ST_ONE;
            out_data_d = cap_data;
            out_err_d  = cap_err;
          end
        end
        ST_ONE: begin
          if (accept && transfer) begin
            out_data_d = cap_data;
            out_err_d  = cap_err;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_data_d = cap_data;
            skid_err_d  = cap_err;
          end else if (transfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a retire can move the buffer.
          if (transfer) begin
            state_d    = ST_ONE;
            out_data_d = skid_data_q;
            out_err_d  = skid_err_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      in_ready_q  <= (state_d != ST_TWO);
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d    = ST_ONE;
      out_data_d = cap_data;
      out_err_d  = cap_err;
    end else if (transfer) begin
      state_d = ST_EMPTY;
    end
  end
`endif

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && cap_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      err_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_sel_err = out_err_q;
  assign err_count   = err_cnt_q;

endmodule
